sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Sequencer for one SHA-256 compression pass. On `start` it captures a 512-bit message block, then walks round index 0..63, presenting the round constant Kt (selected from the packed 2048-bit K table) and message-schedule word Wt each cycle to the round datapath. It signals the datapath when to load working variables, when each round is valid, and when to fold the result back into the hash state. It replaces the free-running counter plus selector with a handshaked controller.

## Interface
Parameters:
- `ROUNDS`, 64, number of compression rounds; fixed at 64 for SHA-256 and kept only for bench shortening.

Ports:
- `clk`  in  1  single clock; all state rises on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request to process `block_in`; honoured only in IDLE.
- `block_in`  in  512  message block; W0 in [511:480], W15 in [31:0].
- `K`  in  2048  packed round constants; K0 in [2047:2016], K63 in [31:0]; static during operation.
- `busy`  out  1  high from the cycle after accept through FINAL.
- `load_state`  out  1  one-cycle pulse in the accept cycle; datapath loads a..h from H.
- `round_valid`  out  1  high while `round`/`kt`/`wt` are valid.
- `round`  out  6  current round index t.
- `kt`  out  32  K[2047-32*t -: 32].
- `wt`  out  32  message schedule word Wt.
- `update_hash`  out  1  one-cycle pulse; datapath adds a..h into H.
- `done`  out  1  one-cycle pulse, coincident with `update_hash`.

## Operation
- FSM states: IDLE, ROUND, FINAL.
- IDLE: `start`=1 → capture `block_in` into 16-word window w[0..15] (w[0]=W0), round counter ← 0, `load_state`=1 this cycle, next ROUND. `start`=0 → stay.
- ROUND: `round_valid`=1, `wt`=w[0], `kt` selected by `round`. Each cycle the window shifts down: w[i] ← w[i+1], w[15] ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32. At `round`=ROUNDS-1 → FINAL, else `round`+1.
- σ0(x)=ROTR7^ROTR18^SHR3; σ1(x)=ROTR17^ROTR19^SHR10. All adds 32-bit wrap, carries discarded.
- FINAL: `update_hash`=1, `done`=1, `round_valid`=0, next IDLE.
- `start` while `busy` (ROUND or FINAL) is ignored and not queued; `block_in` changes after accept have no effect.
- `kt` is combinational from `round`; `wt` is the registered w[0]. Outside ROUND both hold last value but are don't-care; bench must check them only under `round_valid`.

## Timing
- Reset values: state IDLE; `busy`, `load_state`, `round_valid`, `update_hash`, `done` = 0; `round` = 0; window = 0, so `wt` = 0; `kt` = K0 via `round`=0.
- Accept at cycle N (`load_state`=1). Rounds 0..63 at cycles N+1..N+64. `update_hash`/`done` at N+65. Earliest next accept at N+66 (IDLE).
- `busy` = 1 for cycles N+1..N+65 inclusive (65 cycles).
- Reset asserted mid-pass: immediate return to IDLE, all outputs to reset values, no `done`, no `update_hash`; first cycle after release behaves as fresh IDLE.
- `round` wraps never: the counter is held at 63 into FINAL and cleared on the next accept.

## Structure
- `sha256_pkg`: state enum (IDLE/ROUND/FINAL), `sigma0`/`sigma1` functions, constants `WORD_W`=32, `BLOCK_W`=512, `KTAB_W`=2048.
- Sub-module `sha256_msg_sched`: 16×32 window, load/shift enables, outputs `wt`. The FSM, round counter, and K selection stay in the top.

## Test plan
- Reset/idle: hold `reset` 3 cycles then release, no `start` → all flags 0, `round`=0, `wt`=0, `kt`=0x428a2f98 (standard K table).
- "abc" block (`block_in`=0x61626380, then zeros, last word 0x00000018): W0=0x61626380 at N+1, W15=0x00000018 at N+16, W16=0x61626380 at N+17, W17=0x000F0000 at N+18; all 64 Wt match the software model.
- Constant sequencing: standard K → `kt`=0x428a2f98 at round 0 and 0xc67178f2 at round 63; `round_valid` high exactly 64 cycles; `done`/`update_hash` single pulse at N+65.
- `start` held high continuously: accepts at N and N+66 only; `load_state` pulses exactly at those cycles; block changes mid-pass do not alter Wt.
- Reset at round 30: all outputs return to reset values asynchronously (before next edge); no `done`; a new `start` afterwards yields a full correct 64-round pass.
- `start` in FINAL cycle: ignored; IDLE entered, accept occurs only when `start` is seen in IDLE.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, widths and SHA-256 message-schedule helper functions.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int KTAB_W  = 2048;
  localparam int NWORDS  = BLOCK_W / WORD_W;
  localparam int NKT     = KTAB_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message-schedule window. w[0] is the current Wt; each
// shift retires w[0] and appends W(t+16) computed from the window itself.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [BLOCK_W-1:0] block,
  output logic [WORD_W-1:0]  wt
);

  logic [WORD_W-1:0] w [NWORDS];
  logic [WORD_W-1:0] w_next;

  // New tail word: W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t), mod 2^32
  always_comb begin
    w_next = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
  end

  // Window register: clear on reset, parallel load on accept, shift per round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NWORDS; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NWORDS; i++) w[i] <= block[BLOCK_W-1-WORD_W*i -: WORD_W];
    end else if (shift) begin
      for (int i = 0; i < NWORDS-1; i++) w[i] <= w[i+1];
      w[NWORDS-1] <= w_next;
    end
  end

  assign wt = w[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Handshaked sequencer for one SHA-256 compression pass.
// Handshake: start is sampled only in IDLE; the accept cycle is marked by
// load_state, rounds follow on the next ROUNDS cycles with round_valid high,
// then one FINAL cycle pulses update_hash/done. start outside IDLE is dropped.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic [KTAB_W-1:0]  K,
  output logic               busy,
  output logic               load_state,
  output logic               round_valid,
  output logic [5:0]         round,
  output logic [WORD_W-1:0]  kt,
  output logic [WORD_W-1:0]  wt,
  output logic               update_hash,
  output logic               done
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t state;
  state_t state_next;

  logic [WORD_W-1:0] ktab [NKT];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ROUND;
      ROUND:   if (round == LAST_ROUND) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state (and start in IDLE for the accept pulse)
  always_comb begin
    busy        = 1'b0;
    load_state  = 1'b0;
    round_valid = 1'b0;
    update_hash = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:  load_state = start;
      ROUND: begin
        busy        = 1'b1;
        round_valid = 1'b1;
      end
      FINAL: begin
        busy        = 1'b1;
        update_hash = 1'b1;
        done        = 1'b1;
      end
      default: ;
    endcase
  end

  // Round counter: cleared on accept, advances per round, parks on the last round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round <= '0;
    end else if (load_state) begin
      round <= '0;
    end else if (state == ROUND && round != LAST_ROUND) begin
      round <= round + 6'd1;
    end
  end

  // Unpack K so that ktab[t] = K[2047-32*t -: 32]
  for (genvar g = 0; g < NKT; g++) begin : g_ktab
    assign ktab[g] = K[KTAB_W-1-WORD_W*g -: WORD_W];
  end

  assign kt = ktab[round];

  sha256_msg_sched u_msg_sched (
    .clk   (clk),
    .reset (reset),
    .load  (load_state),
    .shift (round_valid),
    .block (block_in),
    .wt    (wt)
  );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: compares every round against a software
// SHA-256 message expansion and a round-constant array.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [31:0] K_STD [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic          clk;
  logic          reset;
  logic          start;
  logic [511:0]  block_in;
  logic [2047:0] K;
  logic          busy;
  logic          load_state;
  logic          round_valid;
  logic [5:0]    round;
  logic [31:0]   kt;
  logic [31:0]   wt;
  logic          update_hash;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] k_cur [64];
  logic [31:0] obs_w [64];
  logic [31:0] exp_q [$];

  sha256_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .block_in    (block_in),
    .K           (K),
    .busy        (busy),
    .load_state  (load_state),
    .round_valid (round_valid),
    .round       (round),
    .kt          (kt),
    .wt          (wt),
    .update_hash (update_hash),
    .done        (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-word expansion pushed onto the expected queue in round order
  task automatic model_schedule(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    exp_q.delete();
    for (int t = 0; t < ROUNDS; t++) exp_q.push_back(w[t]);
  endtask

  task automatic set_k_table(input bit randomize_k);
    for (int i = 0; i < 64; i++) begin
      k_cur[i] = randomize_k ? 32'($urandom) : K_STD[i];
      K[2047-32*i -: 32] = k_cur[i];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'($urandom);
    return r;
  endfunction

  // ---------------- driver: one full pass with per-round scoreboard ----------------
  task automatic do_pass(input logic [511:0] blk, input bit hold, input bit scramble, input string tag);
    logic [31:0] exp_w;
    model_schedule(blk);
    @(negedge clk);
    start    = 1'b1;
    block_in = blk;
    #1;
    checks++;
    if (load_state !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: load_state=%b busy=%b required load_state=1 busy=0", tag, load_state, busy);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    if (scramble) block_in = rand_block();
    for (int t = 0; t < ROUNDS; t++) begin
      @(negedge clk);
      exp_w    = exp_q.pop_front();
      obs_w[t] = wt;
      checks++;
      if (round_valid !== 1'b1 || round !== 6'(t) || busy !== 1'b1 || load_state !== 1'b0 ||
          done !== 1'b0 || update_hash !== 1'b0) begin
        failures++;
        $display("FAIL %s ctrl t=%0d: rv=%b round=%0d busy=%b load=%b done=%b upd=%b required rv=1 round=%0d busy=1 load=0 done=0 upd=0",
                 tag, t, round_valid, round, busy, load_state, done, update_hash, t);
      end
      checks++;
      if (kt !== k_cur[t]) begin
        failures++;
        $display("FAIL %s kt t=%0d: got %h required %h", tag, t, kt, k_cur[t]);
      end
      checks++;
      if (wt !== exp_w) begin
        failures++;
        $display("FAIL %s wt t=%0d: got %h required %h", tag, t, wt, exp_w);
      end
      if (scramble && (t % 8 == 3)) block_in = rand_block();
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || update_hash !== 1'b1 || round_valid !== 1'b0 || busy !== 1'b1 || load_state !== 1'b0) begin
      failures++;
      $display("FAIL %s final: done=%b upd=%b rv=%b busy=%b load=%b required 1 1 0 1 0",
               tag, done, update_hash, round_valid, busy, load_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    block_in = '0;
    set_k_table(1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_state !== 1'b0 || round_valid !== 1'b0 || update_hash !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset flags: busy=%b load=%b rv=%b upd=%b done=%b required all 0",
               busy, load_state, round_valid, update_hash, done);
    end
    checks++;
    if (round !== 6'd0 || wt !== 32'd0 || kt !== 32'h428a2f98) begin
      failures++;
      $display("FAIL reset values: round=%0d wt=%h kt=%h required 0 00000000 428a2f98", round, wt, kt);
    end
  endtask

  task automatic test_abc();
    logic [511:0] blk;
    blk = '0;
    blk[511:480] = 32'h61626380;
    blk[31:0]    = 32'h00000018;
    do_pass(blk, 1'b0, 1'b0, "abc");
    checks++;
    if (obs_w[0] !== 32'h61626380 || obs_w[15] !== 32'h00000018 ||
        obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000f0000) begin
      failures++;
      $display("FAIL abc known words: W0=%h W15=%h W16=%h W17=%h required 61626380 00000018 61626380 000f0000",
               obs_w[0], obs_w[15], obs_w[16], obs_w[17]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || update_hash !== 1'b0) begin
      failures++;
      $display("FAIL abc idle after final: busy=%b done=%b upd=%b required 0 0 0", busy, done, update_hash);
    end
  endtask

  task automatic test_constants();
    do_pass(rand_block(), 1'b0, 1'b0, "kstd");
    checks++;
    if (round !== 6'd63) begin
      failures++;
      $display("FAIL round held in final: got %0d required 63", round);
    end
    set_k_table(1'b1);
    do_pass(rand_block(), 1'b0, 1'b0, "krand");
    set_k_table(1'b0);
  endtask

  task automatic test_random_blocks();
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_pass(rand_block(), 1'b0, 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_pass(rand_block(), 1'b1, 1'b1, "b2b_first");
    do_pass(rand_block(), 1'b1, 1'b1, "b2b_second");
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_state !== 1'b0) begin
      failures++;
      $display("FAIL b2b stop: busy=%b load=%b required 0 0", busy, load_state);
    end
  endtask

  task automatic test_start_in_final();
    do_pass(rand_block(), 1'b0, 1'b0, "final_start");
    start = 1'b1;
    #1;
    checks++;
    if (load_state !== 1'b0) begin
      failures++;
      $display("FAIL start in final: load_state=%b required 0", load_state);
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || load_state !== 1'b0 || round_valid !== 1'b0) begin
        failures++;
        $display("FAIL start in final not queued: busy=%b load=%b rv=%b required 0 0 0", busy, load_state, round_valid);
      end
    end
    do_pass(rand_block(), 1'b0, 1'b0, "after_final");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start    = 1'b1;
    block_in = rand_block();
    @(posedge clk);
    #1 start = 1'b0;
    repeat (31) @(negedge clk);
    checks++;
    if (round !== 6'd30 || round_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid-pass position: round=%0d rv=%b required 30 1", round, round_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || round_valid !== 1'b0 || done !== 1'b0 || update_hash !== 1'b0 ||
        round !== 6'd0 || wt !== 32'd0 || kt !== k_cur[0]) begin
      failures++;
      $display("FAIL async reset: busy=%b rv=%b done=%b upd=%b round=%0d wt=%h kt=%h required 0 0 0 0 0 00000000 %h",
               busy, round_valid, done, update_hash, round, wt, kt, k_cur[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || update_hash !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL no done after reset: done=%b upd=%b busy=%b required 0 0 0", done, update_hash, busy);
      end
    end
    do_pass(rand_block(), 1'b0, 1'b0, "post_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_abc();
    test_constants();
    test_random_blocks();
    test_back_to_back();
    test_start_in_final();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
